mem_byte_streamer: RTL and testbench

// - Consumer stage directly downstream of the word-organised read memory.
// - Issues byte addresses to the memory and captures each returned 4-byte word.
// - Unpacks each word into a byte stream, most significant lane first (lane 0 = bits 31:24).
// - Uses a valid/ready handshake on the output side.
// - Pulses done when the requested byte count has been delivered; done feeds the memory-side done input.

---
 rtl/mem_byte_streamer_pkg.sv | 17 +
 rtl/mem_byte_streamer_if.sv | 19 +
 rtl/mem_byte_streamer.sv | 106 ++++++++++
 tb/tb_mem_byte_streamer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mem_byte_streamer_pkg.sv
// Shared types and constants for the byte streamer.
//   stream_state_t : FSM encoding (IDLE, FETCH, EMIT, FINISH)
//   BYTES_PER_WORD : bytes carried by one memory word
//   LANE_BITS      : width of a byte-lane index inside a word
package mem_stream_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, EMIT, FINISH} stream_state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int LANE_BITS      = 2;

  // True when the lane index points at the last byte of the word.
  function automatic logic is_last_lane(input logic [LANE_BITS-1:0] lane);
    return lane == LANE_BITS'(BYTES_PER_WORD - 1);
  endfunction

endpackage

// File: rtl/mem_byte_streamer_if.sv
// Memory-read and byte-stream signals of the streamer.
//   mem_addr  : word-aligned byte address to the read memory
//   mem_data  : combinational read data, element 0 = most significant byte
//   out_byte  : stream byte
//   out_valid : stream byte valid
//   out_ready : downstream accepts the byte this cycle
// master = streamer side, slave = memory/consumer side.
interface mem_byte_streamer_if #(parameter int NO_BITS = 8);
  logic [NO_BITS-1:0] mem_addr;
  logic [0:3][7:0]    mem_data;
  logic [7:0]         out_byte;
  logic               out_valid;
  logic               out_ready;

  modport master (output mem_addr, out_byte, out_valid,
                  input  mem_data, out_ready);
  modport slave  (input  mem_addr, out_byte, out_valid,
                  output mem_data, out_ready);
endinterface

// File: rtl/mem_byte_streamer.sv
// Fetches 4-byte words from a word-organised read memory and emits them as
// a byte stream, most significant byte first, over valid/ready.
//   clk, rst         : clock, async active-low reset
//   start            : begin a transfer (sampled only when idle)
//   base_addr        : first byte address, low two bits ignored
//   len              : byte count, 0 .. 2^NO_BITS
//   bus (master)     : memory address/data and output stream
//   busy             : transfer in progress
//   done             : one-cycle pulse once the last byte is taken
module mem_byte_streamer
  import mem_stream_pkg::*;
#(
  parameter int NO_BITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [NO_BITS-1:0]    base_addr,
  input  logic [NO_BITS:0]      len,
  mem_byte_streamer_if.master   bus,
  output logic                  busy,
  output logic                  done
);

  stream_state_t                        state, state_nxt;
  logic [NO_BITS-1:0]                   addr_reg, addr_nxt;
  logic [NO_BITS-1:0]                   maddr_reg, maddr_nxt;
  logic [NO_BITS:0]                     remaining, rem_nxt;
  logic [LANE_BITS-1:0]                 lane, lane_nxt;
  logic [0:BYTES_PER_WORD-1][7:0]       word_reg, word_nxt;
  logic                                 accept;

  assign accept = (state == EMIT) && bus.out_ready;

  always_comb begin
    state_nxt = state;
    addr_nxt  = addr_reg;
    maddr_nxt = maddr_reg;
    rem_nxt   = remaining;
    lane_nxt  = lane;
    word_nxt  = word_reg;
    unique case (state)
      IDLE: begin
        if (start) begin
          addr_nxt = base_addr & ~NO_BITS'(BYTES_PER_WORD - 1);
          rem_nxt  = len;
          lane_nxt = '0;
          if (len == '0) begin
            state_nxt = FINISH;
          end else begin
            // Address is presented during FETCH, so load it on entry.
            maddr_nxt = base_addr & ~NO_BITS'(BYTES_PER_WORD - 1);
            state_nxt = FETCH;
          end
        end
      end
      FETCH: begin
        word_nxt  = bus.mem_data;
        state_nxt = EMIT;
      end
      EMIT: begin
        if (accept) begin
          rem_nxt  = remaining - 1'b1;
          lane_nxt = lane + 1'b1;  // wraps to 0 after the last lane
          if (remaining == (NO_BITS+1)'(1)) begin
            state_nxt = FINISH;
          end else if (is_last_lane(lane)) begin
            // Address arithmetic wraps modulo 2^NO_BITS.
            addr_nxt  = addr_reg + NO_BITS'(BYTES_PER_WORD);
            maddr_nxt = addr_reg + NO_BITS'(BYTES_PER_WORD);
            state_nxt = FETCH;
          end
        end
      end
      FINISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      addr_reg  <= '0;
      maddr_reg <= '0;
      remaining <= '0;
      lane      <= '0;
      word_reg  <= '0;
    end else begin
      state     <= state_nxt;
      addr_reg  <= addr_nxt;
      maddr_reg <= maddr_nxt;
      remaining <= rem_nxt;
      lane      <= lane_nxt;
      word_reg  <= word_nxt;
    end
  end

  // Outputs decode straight from registered state, so an async reset
  // clears them in the same cycle and out_byte is stable while stalled.
  assign bus.mem_addr  = maddr_reg;
  assign bus.out_byte  = word_reg[lane];
  assign bus.out_valid = (state == EMIT);
  assign busy          = (state == FETCH) || (state == EMIT);
  assign done          = (state == FINISH);

endmodule

// File: tb/tb_mem_byte_streamer.sv
module tb_mem_byte_streamer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] base_addr = '0;
  logic [8:0] len = '0;
  logic       busy, done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] mem [0:63];
  logic [7:0]  exp_q[$];
  logic [7:0]  fetch_q[$];
  int          done_cnt, acc_cnt, done_cyc, last_acc_cyc, first_vld_cyc;
  logic        stalled = 1'b0;
  logic [7:0]  held = '0;
  int          s;

  mem_byte_streamer_if #(.NO_BITS(8)) bus ();

  mem_byte_streamer #(.NO_BITS(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
    .bus       (bus),
    .busy      (busy),
    .done      (done)
  );

  assign bus.mem_data = mem[bus.mem_addr[7:2]];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Scoreboard/monitor: sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (busy && !bus.out_valid) fetch_q.push_back(bus.mem_addr);
      if (bus.out_valid && stalled) chk("stall_hold", bus.out_byte, held);
      if (bus.out_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (bus.out_valid && bus.out_ready) begin
        acc_cnt++;
        last_acc_cyc = cyc;
        chk("byte_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("byte", bus.out_byte, exp_q.pop_front());
      end
      stalled = bus.out_valid && !bus.out_ready;
      held    = bus.out_byte;
    end else begin
      stalled = 1'b0;
    end
  end

  task automatic push_exp(input logic [7:0] b, input logic [8:0] n);
    logic [7:0]  a, wa;
    logic [31:0] w;
    a = {b[7:2], 2'b00};
    for (int k = 0; k < int'(n); k++) begin
      wa = a + 8'((k / 4) * 4);
      w  = mem[wa[7:2]];
      exp_q.push_back(w[8*(3 - k%4) +: 8]);
    end
  endtask

  task automatic run(input logic [7:0] b, input logic [8:0] n, input bit tog,
                     input int ign_at, output int start_cyc);
    push_exp(b, n);
    done_cnt = 0; acc_cnt = 0; first_vld_cyc = -1;
    fetch_q.delete();
    @(posedge clk); #1;
    base_addr = b; len = n; start = 1'b1; start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 80 && done_cnt == 0; i++) begin
      if (tog) bus.out_ready = ~bus.out_ready;
      if (i == ign_at) begin
        start = 1'b1; len = 9'd3; base_addr = 8'h10;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    bus.out_ready = 1'b1;
    chk("done_seen", done_cnt != 0, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("done_once", done_cnt, 1);
    chk("queue_empty", exp_q.size(), 0);
    chk("byte_count", acc_cnt, 32'(n));
  endtask

  initial begin
    for (int i = 0; i < 64; i++)
      mem[i] = {8'(i), 8'(i + 64), 8'(i + 128), 8'(i + 192)};
    mem[0] = 32'h11223344;
    mem[1] = 32'h55667788;
    bus.out_ready = 1'b1;

    // Reset state.
    #3;
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_byte", bus.out_byte, 0);
    chk("rst_addr", bus.mem_addr, 0);
    @(posedge clk); #1;
    rst = 1'b1;

    // base 0, len 4: four consecutive bytes, valid 2 cycles after start.
    run(8'h00, 9'd4, 1'b0, -1, s);
    chk("len4_first_lat", first_vld_cyc - s, 2);
    chk("len4_done_lat", done_cyc - last_acc_cyc, 1);
    chk("len4_span", last_acc_cyc - first_vld_cyc, 3);

    // base 0, len 6: bubble at mem_addr 4, start while busy ignored.
    run(8'h00, 9'd6, 1'b0, 2, s);
    chk("len6_fetches", fetch_q.size(), 2);
    if (fetch_q.size() == 2) chk("len6_bubble_addr", fetch_q[1], 8'h04);
    chk("len6_span", last_acc_cyc - first_vld_cyc, 6);

    // base 05 -> word 1, len 2, ready toggling.
    bus.out_ready = 1'b1;
    run(8'h05, 9'd2, 1'b1, -1, s);

    // len 0: no valid, done only.
    run(8'h00, 9'd0, 1'b0, -1, s);
    chk("len0_novalid", first_vld_cyc, 32'hFFFF_FFFF);
    chk("len0_done_lat", (done_cyc - s) inside {1, 2}, 1);

    // Address wrap: FC then 00.
    run(8'hFC, 9'd8, 1'b0, -1, s);
    chk("wrap_fetches", fetch_q.size(), 2);
    if (fetch_q.size() == 2) begin
      chk("wrap_addr0", fetch_q[0], 8'hFC);
      chk("wrap_addr1", fetch_q[1], 8'h00);
    end

    // Reset mid-stream after the second byte.
    push_exp(8'h00, 9'd4);
    done_cnt = 0; acc_cnt = 0;
    @(posedge clk); #1;
    base_addr = 8'h00; len = 9'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 20 && acc_cnt < 2; i++) begin
      @(posedge clk); #1;
    end
    chk("mid_two_bytes", acc_cnt, 2);
    rst = 1'b0;
    #1;
    chk("mid_valid", bus.out_valid, 0);
    chk("mid_busy", busy, 0);
    chk("mid_done", done, 0);
    chk("mid_byte", bus.out_byte, 0);
    chk("mid_addr", bus.mem_addr, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_no_done", done, 0);
    end
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle_valid", bus.out_valid, 0);
    chk("post_rst_no_done", done_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
